// File: rtl/ql_reserved_pkg.sv
// Shared definitions for the QuickLogic-reserved register window and bus watchdog:
// register offsets, field positions, watchdog state encoding and ID defaults.
package ql_reserved_pkg;

  // Word offsets inside the 8-word reserved window (byte offset >> 2)
  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_ERR_ADR = 3'd2;
  localparam logic [2:0] OFF_ERR_CNT = 3'd3;
  localparam logic [2:0] OFF_SCRATCH = 3'd4;
  localparam logic [2:0] OFF_ID      = 3'd6;
  localparam logic [2:0] OFF_REV     = 3'd7;

  localparam int CTRL_WD_EN       = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_TIMEOUT_LSB = 8;
  localparam int STATUS_TO        = 0;
  localparam int STATUS_OVF       = 1;
  localparam int ERR_ADR_WE       = 31;

  localparam logic [7:0]  DEF_CUSTOMER_ID = 8'h01;
  localparam logic [7:0]  DEF_PRODUCT_ID  = 8'h00;
  localparam logic [15:0] DEF_MAJOR_REV   = 16'h0001;
  localparam logic [15:0] DEF_MINOR_REV   = 16'h0000;

  typedef enum logic [1:0] {
    WD_IDLE  = 2'd0,
    WD_COUNT = 2'd1,
    WD_FLUSH = 2'd2
  } wd_state_e;

  // Expands four byte enables into a per-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ql_reserved_watchdog.sv
// Bus watchdog: counts down from the programmed timeout once a transfer starts and
// issues a default acknowledge plus a timeout pulse if nobody acknowledges in time.
module ql_reserved_watchdog
  import ql_reserved_pkg::*;
#(
  parameter int TIMEOUT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wd_en,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 cyc,
  input  logic                 stb,
  input  logic                 ack_in,
  output logic                 dflt_ack_nxt,
  output logic                 to_event
);

  localparam logic [TIMEOUT_W-1:0] T_MIN = TIMEOUT_W'(2);
  localparam logic [TIMEOUT_W-1:0] T_ONE = TIMEOUT_W'(1);

  wd_state_e            state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic [TIMEOUT_W-1:0] load_val;

  // A timeout below 2 cannot be honoured: the FSM needs one COUNT cycle to see an ack.
  assign load_val = (timeout < T_MIN) ? T_MIN : timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dflt_ack_nxt = 1'b0;
    to_event     = 1'b0;
    case (state)
      WD_IDLE: begin
        cnt_nxt = load_val;
        if (wd_en && cyc && stb) state_nxt = WD_COUNT;
      end
      WD_COUNT: begin
        cnt_nxt = cnt - T_ONE;
        if (ack_in || !wd_en) begin
          state_nxt = WD_IDLE;
        end else if (cnt == T_ONE) begin
          dflt_ack_nxt = 1'b1;
          to_event     = 1'b1;
          state_nxt    = WD_FLUSH;
        end
      end
      // The master still holds STB while our default ack is on the bus.
      WD_FLUSH: state_nxt = WD_IDLE;
      default:  state_nxt = WD_IDLE;
    endcase
  end

endmodule

// File: rtl/ql_reserved_bus_watchdog.sv
// QuickLogic-reserved register window with ID/revision words, scratch register and
// a programmable bus-timeout watchdog that records timeouts and can raise an IRQ.
module ql_reserved_bus_watchdog
  import ql_reserved_pkg::*;
#(
  parameter int                   ADDRWIDTH     = 10,
  parameter int                   DATAWIDTH     = 32,
  parameter logic [ADDRWIDTH-1:0] RSV_BASE_ADR  = 'h1E0,
  parameter logic [7:0]           CUSTOMER_ID   = DEF_CUSTOMER_ID,
  parameter logic [7:0]           PRODUCT_ID    = DEF_PRODUCT_ID,
  parameter logic [15:0]          MAJOR_REV     = DEF_MAJOR_REV,
  parameter logic [15:0]          MINOR_REV     = DEF_MINOR_REV,
  parameter logic [31:0]          DEF_REG_VALUE = 32'hDEFFABAC,
  parameter int                   TIMEOUT_W     = 4,
  parameter int                   TIMEOUT_DEF   = 7
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RSTn_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_QL_Reserved_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 Timeout_Irq_o
);

  logic                 wd_en, irq_en;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 sts_to, sts_ovf;
  logic [ADDRWIDTH-1:0] err_adr;
  logic                 err_we;
  logic [15:0]          err_cnt;
  logic [31:0]          scratch;

  logic [2:0]  off;
  logic        in_win, reg_ack_nxt, wr;
  logic        wr_ctrl, wr_status, wr_cnt, wr_scratch;
  logic        clr_to, clr_ovf;
  logic [31:0] wmask, ctrl_word, rd_data;
  logic        dflt_ack_nxt, to_event;

  assign off         = WBs_ADR_i[4:2];
  assign in_win      = WBs_ADR_i[ADDRWIDTH-1:5] == RSV_BASE_ADR[ADDRWIDTH-1:5];
  assign reg_ack_nxt = WBs_CYC_QL_Reserved_i & WBs_STB_i & ~WBs_ACK_o;
  // Writes commit on the same edge that raises the register ack.
  assign wr          = reg_ack_nxt & WBs_WE_i & in_win;
  assign wr_ctrl     = wr & (off == OFF_CTRL);
  assign wr_status   = wr & (off == OFF_STATUS);
  assign wr_cnt      = wr & (off == OFF_ERR_CNT);
  assign wr_scratch  = wr & (off == OFF_SCRATCH);
  assign wmask       = byte_mask(WBs_BYTE_STB_i);
  assign clr_to      = wr_status & wmask[STATUS_TO]  & WBs_DAT_i[STATUS_TO];
  assign clr_ovf     = wr_status & wmask[STATUS_OVF] & WBs_DAT_i[STATUS_OVF];

  ql_reserved_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wd (
    .clk          (WBs_CLK_i),
    .rst_n        (WBs_RSTn_i),
    .wd_en        (wd_en),
    .timeout      (timeout),
    .cyc          (WBs_CYC_i),
    .stb          (WBs_STB_i),
    .ack_in       (WBs_ACK_i),
    .dflt_ack_nxt (dflt_ack_nxt),
    .to_event     (to_event)
  );

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      wd_en         <= 1'b1;
      irq_en        <= 1'b0;
      timeout       <= TIMEOUT_W'(TIMEOUT_DEF);
      sts_to        <= 1'b0;
      sts_ovf       <= 1'b0;
      err_adr       <= '0;
      err_we        <= 1'b0;
      err_cnt       <= '0;
      scratch       <= '0;
      WBs_ACK_o     <= 1'b0;
      Timeout_Irq_o <= 1'b0;
    end else begin
      WBs_ACK_o     <= reg_ack_nxt | dflt_ack_nxt;
      Timeout_Irq_o <= sts_to & irq_en;

      if (wr_ctrl) begin
        wd_en   <= (wd_en & ~wmask[CTRL_WD_EN]) | (WBs_DAT_i[CTRL_WD_EN] & wmask[CTRL_WD_EN]);
        irq_en  <= (irq_en & ~wmask[CTRL_IRQ_EN]) | (WBs_DAT_i[CTRL_IRQ_EN] & wmask[CTRL_IRQ_EN]);
        timeout <= (timeout & ~wmask[CTRL_TIMEOUT_LSB +: TIMEOUT_W])
                 | (WBs_DAT_i[CTRL_TIMEOUT_LSB +: TIMEOUT_W] & wmask[CTRL_TIMEOUT_LSB +: TIMEOUT_W]);
      end
      if (wr_scratch) scratch <= (scratch & ~wmask) | (WBs_DAT_i & wmask);

      // A W1C of TO landing with a new timeout counts as a fresh first timeout.
      sts_to  <= (sts_to & ~clr_to) | to_event;
      sts_ovf <= (sts_ovf & ~clr_ovf) | (to_event & sts_to & ~clr_to);
      if (to_event && (!sts_to || clr_to)) begin
        err_adr <= WBs_ADR_i;
        err_we  <= WBs_WE_i;
      end

      if (wr_cnt)                              err_cnt <= to_event ? 16'd1 : 16'd0;
      else if (to_event && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_WD_EN]                       = wd_en;
    ctrl_word[CTRL_IRQ_EN]                      = irq_en;
    ctrl_word[CTRL_TIMEOUT_LSB +: TIMEOUT_W]    = timeout;
  end

  always_comb begin
    rd_data = DEF_REG_VALUE;
    if (in_win) begin
      case (off)
        OFF_CTRL:    rd_data = ctrl_word;
        OFF_STATUS: begin
          rd_data             = '0;
          rd_data[STATUS_TO]  = sts_to;
          rd_data[STATUS_OVF] = sts_ovf;
        end
        OFF_ERR_ADR: begin
          rd_data                  = '0;
          rd_data[ADDRWIDTH-1:0]   = err_adr;
          rd_data[ERR_ADR_WE]      = err_we;
        end
        OFF_ERR_CNT: rd_data = {16'h0000, err_cnt};
        OFF_SCRATCH: rd_data = scratch;
        OFF_ID:      rd_data = {16'h0000, CUSTOMER_ID, PRODUCT_ID};
        OFF_REV:     rd_data = {MAJOR_REV, MINOR_REV};
        default:     rd_data = DEF_REG_VALUE;
      endcase
    end
  end

  assign WBs_DAT_o = rd_data;

endmodule

// File: tb/tb_ql_reserved_bus_watchdog.sv
// Self-checking bench for ql_reserved_bus_watchdog: a simple Wishbone master with a
// read-data scoreboard, plus per-feature tasks checking ack timing and status.
module tb_ql_reserved_bus_watchdog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  adr = '0;
  logic        cyc_rsv = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdat = '0;
  logic        ip_ack = 1'b0;
  logic        ack_in;
  logic [31:0] rdat;
  logic        ack, irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  localparam logic [9:0] A_CTRL = 10'h1E0, A_STATUS = 10'h1E4, A_ERR_ADR = 10'h1E8,
                         A_ERR_CNT = 10'h1EC, A_SCRATCH = 10'h1F0, A_UNDEF = 10'h1F4,
                         A_ID = 10'h1F8, A_REV = 10'h1FC;

  // Top-level ack is the OR of this block's ack and the user IP ack.
  assign ack_in = ack | ip_ack;

  always #5 clk = ~clk;

  ql_reserved_bus_watchdog dut (
    .WBs_CLK_i             (clk),
    .WBs_RSTn_i            (rst_n),
    .WBs_ADR_i             (adr),
    .WBs_CYC_QL_Reserved_i (cyc_rsv),
    .WBs_CYC_i             (cyc),
    .WBs_STB_i             (stb),
    .WBs_WE_i              (we),
    .WBs_BYTE_STB_i        (be),
    .WBs_DAT_i             (wdat),
    .WBs_ACK_i             (ack_in),
    .WBs_DAT_o             (rdat),
    .WBs_ACK_o             (ack),
    .Timeout_Irq_o         (irq)
  );

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // One transfer. k counts edges from the first one that samples CYC&STB.
  // An IP ack pulse (ip_ack_at > 0) is sampled on edge ip_ack_at.
  task automatic wb_access(input logic [9:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] b, input int ip_ack_at, input int budget,
                           output int ack_at, output int n_acks, output int irq_at);
    int          tail;
    bit          done;
    logic [31:0] rdata;
    logic [31:0] e;
    string       nm;
    ack_at = -1; n_acks = 0; irq_at = -1; tail = 0; done = 1'b0; rdata = 'x;
    @(posedge clk); #1;
    adr = a; we = w; wdat = d; be = b; cyc = 1'b1; stb = 1'b1;
    cyc_rsv = (a[9:5] == 5'h0F);
    for (int k = 0; k <= budget + 4; k++) begin
      @(posedge clk); #1;
      ip_ack = !done && (k + 1 == ip_ack_at);
      if (ack) begin
        n_acks++;
        if (ack_at < 0) begin
          ack_at = k;
          rdata  = rdat;
        end
      end
      if (irq && irq_at < 0) irq_at = k;
      if (!done && (ack || k == ip_ack_at || k == budget)) begin
        done = 1'b1;
        cyc = 1'b0; stb = 1'b0; cyc_rsv = 1'b0; we = 1'b0;
        if (!w && exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          n_vec++;
          if (ack_at < 0 || rdata !== e) begin
            n_err++;
            $display("FAIL %s: read %h, expected %h", nm, rdata, e);
          end
        end
      end else if (done) begin
        tail++;
        if (tail == 3) break;
      end
    end
    ip_ack = 1'b0;
  endtask

  task automatic reg_rd(input logic [9:0] a, input logic [31:0] e, input string nm);
    int at, n, q;
    exp_q.push_back(e);
    name_q.push_back(nm);
    wb_access(a, 1'b0, '0, 4'hF, -1, 20, at, n, q);
    n_vec++;
    if (at != 0 || n != 1) begin
      n_err++;
      $display("FAIL %s_ack: ack at %0d (%0d acks), expected at 0 (1 ack)", nm, at, n);
    end
  endtask

  task automatic reg_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    int at, n, q;
    wb_access(a, 1'b1, d, b, -1, 20, at, n, q);
    n_vec++;
    if (at != 0 || n != 1) begin
      n_err++;
      $display("FAIL wr_ack_%h: ack at %0d (%0d acks), expected at 0 (1 ack)", a, at, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (ack !== 1'b0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%b irq=%b, expected 0 0", ack, irq);
    end
    rst_n = 1'b1;
    reg_rd(A_ID,      32'h0000_0100, "rst_id");
    reg_rd(A_REV,     32'h0001_0000, "rst_rev");
    reg_rd(A_CTRL,    32'h0000_0701, "rst_ctrl");
    reg_rd(A_STATUS,  32'h0000_0000, "rst_status");
    reg_rd(A_ERR_ADR, 32'h0000_0000, "rst_err_adr");
    reg_rd(A_ERR_CNT, 32'h0000_0000, "rst_err_cnt");
    reg_rd(A_SCRATCH, 32'h0000_0000, "rst_scratch");
    reg_rd(A_UNDEF,   32'hDEFF_ABAC, "rst_undef");
  endtask

  task automatic expect_timeout(input logic [9:0] a, input logic w, input int t, input string nm);
    int at, n, q;
    wb_access(a, w, 32'h1111_2222, 4'hF, -1, 20, at, n, q);
    n_vec++;
    if (at != t || n != 1) begin
      n_err++;
      $display("FAIL %s: default ack at %0d (%0d acks), expected at %0d (1 ack)", nm, at, n, t);
    end
  endtask

  task automatic test_timeout();
    expect_timeout(10'h040, 1'b0, 7, "to_first");
    reg_rd(A_STATUS,  32'h0000_0001, "to1_status");
    reg_rd(A_ERR_ADR, 32'h0000_0040, "to1_err_adr");
    reg_rd(A_ERR_CNT, 32'h0000_0001, "to1_err_cnt");
    expect_timeout(10'h080, 1'b1, 7, "to_second");
    reg_rd(A_STATUS,  32'h0000_0003, "to2_status");
    reg_rd(A_ERR_ADR, 32'h0000_0040, "to2_err_adr");
    reg_rd(A_ERR_CNT, 32'h0000_0002, "to2_err_cnt");
    reg_wr(A_STATUS, 32'h0000_0003, 4'b1110);
    reg_rd(A_STATUS,  32'h0000_0003, "w1c_lane0_only");
    reg_wr(A_STATUS, 32'h0000_0003, 4'b0001);
    reg_rd(A_STATUS,  32'h0000_0000, "w1c_clear");
    reg_wr(A_ERR_CNT, 32'h0000_0000, 4'b0000);
    reg_rd(A_ERR_CNT, 32'h0000_0000, "err_cnt_clear");
    expect_timeout(10'h0C4, 1'b1, 7, "to_write");
    reg_rd(A_ERR_ADR, 32'h8000_00C4, "to3_err_adr_we");
    reg_rd(A_ERR_CNT, 32'h0000_0001, "to3_err_cnt");
    reg_wr(A_STATUS, 32'h0000_0003, 4'b0001);
    reg_wr(A_ERR_CNT, 32'h0000_0000, 4'b1111);
  endtask

  task automatic test_ext_ack();
    int at, n, q;
    int ack_pts[2] = '{3, 7};
    foreach (ack_pts[i]) begin
      wb_access(10'h040, 1'b0, '0, 4'hF, ack_pts[i], 20, at, n, q);
      n_vec++;
      if (at != -1 || n != 0) begin
        n_err++;
        $display("FAIL ext_ack_%0d: own ack at %0d (%0d acks), expected none", ack_pts[i], at, n);
      end
      reg_rd(A_STATUS,  32'h0000_0000, "ext_ack_status");
      reg_rd(A_ERR_CNT, 32'h0000_0000, "ext_ack_err_cnt");
    end
  endtask

  task automatic test_ctrl_irq();
    int at, n, q;
    logic [31:0] ctrl_tab[3] = '{32'h0000_0003, 32'h0000_0103, 32'h0000_0F03};
    int          t_tab[3]    = '{2, 2, 15};
    reg_wr(A_CTRL, 32'h0000_0303, 4'hF);
    reg_rd(A_CTRL, 32'h0000_0303, "ctrl_t3");
    wb_access(10'h200, 1'b0, '0, 4'hF, -1, 20, at, n, q);
    n_vec++;
    if (at != 3 || n != 1 || q != 4) begin
      n_err++;
      $display("FAIL t3_irq: ack at %0d (%0d acks) irq at %0d, expected 3 (1) irq 4", at, n, q);
    end
    foreach (ctrl_tab[i]) begin
      reg_wr(A_CTRL, ctrl_tab[i], 4'hF);
      expect_timeout(10'h300, 1'b0, t_tab[i], "prog_timeout");
    end
    reg_wr(A_STATUS, 32'h0000_0003, 4'b0001);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: irq=%b, expected 0", irq);
    end
    reg_wr(A_CTRL, 32'h0000_0700, 4'hF);
    wb_access(10'h040, 1'b0, '0, 4'hF, -1, 20, at, n, q);
    n_vec++;
    if (at != -1 || n != 0) begin
      n_err++;
      $display("FAIL wd_disabled: ack at %0d (%0d acks), expected none", at, n);
    end
    reg_rd(A_STATUS, 32'h0000_0000, "wd_disabled_status");
    reg_wr(A_CTRL, 32'h0000_0701, 4'hF);
    reg_wr(A_CTRL, 32'hFFFF_FFFF, 4'b0010);
    reg_rd(A_CTRL, 32'h0000_0F01, "ctrl_byte1_only");
    reg_wr(A_CTRL, 32'h0000_0701, 4'hF);
    reg_rd(A_CTRL, 32'h0000_0701, "ctrl_restore");
  endtask

  task automatic test_reset_mid();
    int acks;
    reg_wr(A_CTRL, 32'h0000_0703, 4'hF);
    expect_timeout(10'h044, 1'b0, 7, "pre_reset_to");
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_irq: irq=%b, expected 1", irq);
    end
    reg_wr(A_SCRATCH, 32'h1234_5678, 4'hF);
    reg_rd(A_SCRATCH, 32'h1234_5678, "scratch_pre");
    @(posedge clk); #1;
    adr = 10'h100; we = 1'b0; cyc = 1'b1; stb = 1'b1; cyc_rsv = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ack !== 1'b0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: ack=%b irq=%b, expected 0 0", ack, irq);
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL post_reset_ack: %0d acks, expected 0", acks);
    end
    reg_rd(A_SCRATCH, 32'h0000_0000, "mid_rst_scratch");
    reg_rd(A_STATUS,  32'h0000_0000, "mid_rst_status");
    reg_rd(A_ERR_ADR, 32'h0000_0000, "mid_rst_err_adr");
    reg_rd(A_ERR_CNT, 32'h0000_0000, "mid_rst_err_cnt");
    reg_rd(A_CTRL,    32'h0000_0701, "mid_rst_ctrl");
    // Reset while a register ack is on the bus must drop it at once.
    @(posedge clk); #1;
    adr = A_ID; cyc = 1'b1; stb = 1'b1; cyc_rsv = 1'b1;
    @(posedge clk); #2;
    n_vec++;
    if (ack !== 1'b1) begin
      n_err++;
      $display("FAIL ack_before_reset: ack=%b, expected 1", ack);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL ack_async_reset: ack=%b, expected 0", ack);
    end
    cyc = 1'b0; stb = 1'b0; cyc_rsv = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    reg_wr(A_SCRATCH, 32'hA5A5_A5A5, 4'b0101);
    reg_rd(A_SCRATCH, 32'h00A5_00A5, "scratch_be0101");
    reg_wr(A_SCRATCH, 32'h3C3C_3C3C, 4'b1000);
    reg_rd(A_SCRATCH, 32'h3CA5_00A5, "scratch_be1000");
    reg_rd(A_ID,      32'h0000_0100, "b2b_id");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_ext_ack();
    test_ctrl_irq();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
